ram16k_arbiter: RTL and testbench



---
 rtl/ram16k_pkg.sv | 16 +
 rtl/ram16k_arbiter_arb_rr2.sv | 21 ++
 rtl/ram16k_arbiter.sv | 77 +++++++
 tb/tb_ram16k_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ram16k_pkg.sv
// ram16k_pkg: shared widths, requester ids and command/tag types for the 16K x 16 RAM arbiter
package ram16k_pkg;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;
  localparam logic REQ_ID_0 = 1'b0;
  localparam logic REQ_ID_1 = 1'b1;
  typedef struct packed {
    logic write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;
  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;
endpackage

// File: rtl/ram16k_arbiter_arb_rr2.sv
// arb_rr2: two-way grant with optional round-robin tie-break
// ports: clk, reset (async, active-low), valid[1:0], fire (a grant was accepted), grant[1:0]
module arb_rr2 #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       fire,
  output logic [1:0] grant
);
  logic last_grant;
  // requester 0 wins a tie unless round-robin and it won the last handshake
  always_comb begin
    grant[0] = valid[0] & (~valid[1] | ~ROUND_ROBIN | last_grant);
    grant[1] = valid[1] & ~grant[0];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) last_grant <= 1'b1;
    else if (fire) last_grant <= grant[1];
endmodule

// File: rtl/ram16k_arbiter.sv
// ram16k_arbiter: two-requester arbiter and 2-cycle sequencer for the shared 16K x 16 RAM
// ports: clk, reset (async, active-low); reqN_valid/write/addr/wdata in, reqN_ready out;
//        rspN_valid/rdata out; ram_reset/load/address/in to the RAM, ram_out from it
module ram16k_arbiter
  import ram16k_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              ram_reset,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out
);
  logic init_q;
  logic fire;
  logic [1:0] grant;
  cmd_t cmd;
  tag_t tag1, tag2;
  arb_rr2 #(.ROUND_ROBIN(ROUND_ROBIN)) u_arb (
    .clk   (clk),
    .reset (reset),
    .valid ({req1_valid, req0_valid}),
    .fire  (fire),
    .grant (grant)
  );
  always_comb begin
    req0_ready = grant[0] & ~init_q;
    req1_ready = grant[1] & ~init_q;
    fire = req0_ready | req1_ready;
    cmd = req1_ready ? {req1_write, req1_addr, req1_wdata} : {req0_write, req0_addr, req0_wdata};
    // gating rdata with valid keeps it 0 while the RAM output register is still stale after reset
    rsp0_valid = tag2.valid & (tag2.id == REQ_ID_0);
    rsp1_valid = tag2.valid & (tag2.id == REQ_ID_1);
    rsp0_rdata = rsp0_valid ? ram_out : '0;
    rsp1_rdata = rsp1_valid ? ram_out : '0;
    ram_reset = init_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) init_q <= 1'b1;
    else init_q <= 1'b0;
  // address and data hold between commands so the RAM pins only move on a handshake
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ram_load <= 1'b0;
      ram_address <= '0;
      ram_in <= '0;
      tag1 <= '0;
    end else if (fire) begin
      ram_load <= cmd.write;
      ram_address <= cmd.addr;
      ram_in <= cmd.wdata;
      tag1 <= '{valid: 1'b1, id: req1_ready};
    end else begin
      ram_load <= 1'b0;
      tag1.valid <= 1'b0;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) tag2 <= '0;
    else tag2 <= tag1;
endmodule

// File: tb/tb_ram16k_arbiter.sv
// tb_ram16k_arbiter: scoreboard bench for ram16k_arbiter with a read-before-write RAM model
module tb_ram16k_arbiter;
  typedef struct {
    int due;
    logic [15:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req0_valid = 1'b0, req0_write = 1'b0, req1_valid = 1'b0, req1_write = 1'b0;
  logic [13:0] req0_addr = '0, req1_addr = '0;
  logic [15:0] req0_wdata = '0, req1_wdata = '0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [15:0] rsp0_rdata, rsp1_rdata;
  logic ram_reset, ram_load;
  logic [13:0] ram_address;
  logic [15:0] ram_in, ram_out;
  logic fp_ready0, fp_ready1, fp_rsp0_valid, fp_rsp1_valid, fp_ram_reset, fp_ram_load;
  logic [15:0] fp_rsp0_rdata, fp_rsp1_rdata, fp_ram_in;
  logic [13:0] fp_ram_address;
  logic [15:0] mem [16384];
  logic [15:0] shadow [16384];
  exp_t q0[$], q1[$];
  exp_t e;
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  ram16k_arbiter #(.ROUND_ROBIN(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_reset(ram_reset), .ram_load(ram_load), .ram_address(ram_address), .ram_in(ram_in), .ram_out(ram_out)
  );
  ram16k_arbiter #(.ROUND_ROBIN(1'b0)) u_fp (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(fp_ready0),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(fp_ready1),
    .rsp0_valid(fp_rsp0_valid), .rsp0_rdata(fp_rsp0_rdata), .rsp1_valid(fp_rsp1_valid), .rsp1_rdata(fp_rsp1_rdata),
    .ram_reset(fp_ram_reset), .ram_load(fp_ram_load), .ram_address(fp_ram_address), .ram_in(fp_ram_in), .ram_out(16'h0000)
  );
  always @(posedge clk)
    if (ram_reset) ram_out <= '0;
    else begin
      ram_out <= mem[ram_address];
      if (ram_load) mem[ram_address] <= ram_in;
    end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (q0.size() != 0 && q0[0].due == cyc) begin
        e = q0.pop_front();
        check("rsp0_valid", 32'(rsp0_valid), 1);
        check("rsp0_rdata", 32'(rsp0_rdata), 32'(e.data));
      end else check("rsp0_idle", 32'({rsp0_valid, rsp0_rdata}), 0);
      if (q1.size() != 0 && q1[0].due == cyc) begin
        e = q1.pop_front();
        check("rsp1_valid", 32'(rsp1_valid), 1);
        check("rsp1_rdata", 32'(rsp1_rdata), 32'(e.data));
      end else check("rsp1_idle", 32'({rsp1_valid, rsp1_rdata}), 0);
      if (req0_valid && req0_ready) begin
        q0.push_back('{cyc + 2, shadow[req0_addr]});
        if (req0_write) shadow[req0_addr] = req0_wdata;
      end
      if (req1_valid && req1_ready) begin
        q1.push_back('{cyc + 2, shadow[req1_addr]});
        if (req1_write) shadow[req1_addr] = req1_wdata;
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int id, input logic w, input logic [13:0] a, input logic [15:0] d);
    if (id == 0) begin
      req0_valid = 1'b1; req0_write = w; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = 1'b1; req1_write = w; req1_addr = a; req1_wdata = d;
    end
    @(negedge clk);
    check(id == 0 ? "ready0" : "ready1", 32'(id == 0 ? req0_ready : req1_ready), 1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i] = '0;
      shadow[i] = '0;
    end
    req0_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ram_reset", 32'(ram_reset), 1);
    check("rst_ready0", 32'(req0_ready), 0);
    check("rst_rsp", 32'({rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata}), 0);
    check("rst_ram_pins", 32'({ram_load, ram_address, ram_in}), 0);
    step();
    reset = 1'b1;
    @(negedge clk);
    check("rel_ram_reset", 32'(ram_reset), 1);
    check("rel_ready0", 32'(req0_ready), 0);
    step();
    check("run_ram_reset", 32'(ram_reset), 0);
    step();
    req0_valid = 1'b0;
    send(0, 1'b1, 14'h0005, 16'hBEEF);
    send(0, 1'b0, 14'h0005, 16'h0000);
    repeat (3) step();
    send(0, 1'b1, 14'h0001, 16'h1111);
    send(1, 1'b1, 14'h3FFF, 16'h2222);
    send(1, 1'b1, 14'h2000, 16'h5555);
    repeat (2) step();
    send(1, 1'b1, 14'h2000, 16'h1234);
    send(1, 1'b0, 14'h2000, 16'h0000);
    repeat (3) step();
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 14'h0001;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 14'h3FFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr_grant0", 32'(req0_ready), 32'(i % 2 == 0));
      check("rr_grant1", 32'(req1_ready), 32'(i % 2 == 1));
      check("fp_grant0", 32'(fp_ready0), 1);
      check("fp_grant1", 32'(fp_ready1), 0);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) step();
    send(0, 1'b0, 14'h0005, 16'h0000);
    reset = 1'b0;
    req0_valid = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    check("mid_ready", 32'({req0_ready, req1_ready}), 0);
    check("mid_rsp", 32'({rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata}), 0);
    check("mid_ram_pins", 32'({ram_load, ram_address, ram_in}), 0);
    check("mid_ram_reset", 32'(ram_reset), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_no_rsp", 32'({rsp0_valid, rsp1_valid}), 0);
    end
    step();
    req0_valid = 1'b0;
    reset = 1'b1;
    step();
    send(0, 1'b0, 14'h0005, 16'h0000);
    send(1, 1'b0, 14'h2000, 16'h0000);
    repeat (5) step();
    check("q0_drain", 32'(q0.size()), 0);
    check("q1_drain", 32'(q1.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
